rx_shift_unstuff: RTL



---
 rtl/usb_rx_pkg.sv | 14 +
 rtl/nrzi_unstuff.sv | 71 +++++++
 rtl/rx_shift_unstuff.sv | 87 ++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared constants and bit classification for the USB full-speed receive datapath.
package usb_rx_pkg;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   STUFF_RUN  = 6;
    localparam int   BYTE_BITS  = 8;

    typedef enum logic [1:0] {
        BIT_DATA,
        BIT_STUFFED,
        BIT_STUFF_ERR
    } bit_kind_t;

endpackage

// File: rtl/nrzi_unstuff.sv
// NRZI decoder with stuffed-bit classification; tracks the previous line level and the run of ones.
// Stuff detection is present only when RX_BIT_UNSTUFF_EN is defined.
module nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int RUN = STUFF_RUN
) (
    input  logic      clk,
    input  logic      n_rst,
    input  logic      sample,
    input  logic      clear,
    input  logic      d_plus_sync,
    output logic      bit_valid,
    output logic      bit_value,
    output bit_kind_t bit_kind
);

    logic prev_level;
    logic decoded;

    assign decoded   = (d_plus_sync == prev_level);
    assign bit_valid = sample;
    assign bit_value = decoded;

`ifdef RX_BIT_UNSTUFF_EN
    localparam int            CW      = $clog2(RUN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(RUN);

    logic [CW-1:0] ones_cnt;

    always_comb begin
        bit_kind = BIT_DATA;
        if (ones_cnt == RUN_MAX) begin
            bit_kind = decoded ? BIT_STUFF_ERR : BIT_STUFFED;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_level <= IDLE_LEVEL;
            ones_cnt   <= '0;
        end else if (clear) begin
            prev_level <= IDLE_LEVEL;
            ones_cnt   <= '0;
        end else if (sample) begin
            prev_level <= d_plus_sync;
            // A full run stays saturated on a violation so every further 1 is flagged too.
            if (ones_cnt == RUN_MAX) begin
                if (!decoded) ones_cnt <= '0;
            end else if (decoded) begin
                ones_cnt <= ones_cnt + 1'b1;
            end else begin
                ones_cnt <= '0;
            end
        end
    end
`else
    assign bit_kind = BIT_DATA;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_level <= IDLE_LEVEL;
        end else if (clear) begin
            prev_level <= IDLE_LEVEL;
        end else if (sample) begin
            prev_level <= d_plus_sync;
        end
    end
`endif

endmodule

// File: rtl/rx_shift_unstuff.sv
// Receive shifter: NRZI decode, bit unstuffing and LSB-first byte assembly with a one-cycle byte strobe.
// Optional macro RX_BIT_UNSTUFF_EN enables stuffed-bit removal and the stuff_err flag.
module rx_shift_unstuff
    import usb_rx_pkg::*;
#(
    parameter int BYTE_BITS = usb_rx_pkg::BYTE_BITS,
    parameter int STUFF_RUN = usb_rx_pkg::STUFF_RUN
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 d_plus_sync,
    input  logic                 shift_enable,
    input  logic                 eop,
    input  logic                 clear,
    output logic [BYTE_BITS-1:0] rx_data,
    output logic                 byte_valid,
    output logic [2:0]           bit_count,
    output logic                 stuff_err
);

    localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

    logic                 sample;
    logic                 bit_valid;
    logic                 bit_value;
    bit_kind_t            bit_kind;
    logic [BYTE_BITS-1:0] sr;
    logic [BYTE_BITS-1:0] sr_next;
    logic                 data_bit;

    assign sample   = shift_enable && !eop && !clear;
    assign data_bit = bit_valid && (bit_kind == BIT_DATA);
    assign sr_next  = {bit_value, sr[BYTE_BITS-1:1]};

    nrzi_unstuff #(
        .RUN(STUFF_RUN)
    ) u_nrzi (
        .clk        (clk),
        .n_rst      (n_rst),
        .sample     (sample),
        .clear      (clear),
        .d_plus_sync(d_plus_sync),
        .bit_valid  (bit_valid),
        .bit_value  (bit_value),
        .bit_kind   (bit_kind)
    );

    // rx_data deliberately survives clear; only reset wipes it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr         <= '0;
            bit_count  <= '0;
            rx_data    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (clear) begin
                sr        <= '0;
                bit_count <= '0;
            end else if (data_bit) begin
                sr <= sr_next;
                if (bit_count == LAST_BIT) begin
                    bit_count  <= '0;
                    rx_data    <= sr_next;
                    byte_valid <= 1'b1;
                end else begin
                    bit_count <= bit_count + 1'b1;
                end
            end
        end
    end

`ifdef RX_BIT_UNSTUFF_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stuff_err <= 1'b0;
        end else if (clear) begin
            stuff_err <= 1'b0;
        end else if (bit_valid && bit_kind == BIT_STUFF_ERR) begin
            stuff_err <= 1'b1;
        end
    end
`else
    assign stuff_err = 1'b0;
`endif

endmodule
